// File: rtl/remote_stroke_interp_if.sv
// Code-in / pixel-out link between the differential receiver side and the
// frame-buffer write port. The master drives codes and ready; the slave is the
// stroke interpolator.
interface remote_stroke_interp_if;
    logic [25:0] code_in;
    logic        new_code_in;
    logic        pix_ready_in;
    logic        pix_valid_out;
    logic [9:0]  pix_x_out;
    logic [8:0]  pix_y_out;
    logic [3:0]  pix_color_out;
    logic [2:0]  pix_sw_out;

    modport master (
        output code_in, new_code_in, pix_ready_in,
        input  pix_valid_out, pix_x_out, pix_y_out, pix_color_out, pix_sw_out
    );

    modport slave (
        input  code_in, new_code_in, pix_ready_in,
        output pix_valid_out, pix_x_out, pix_y_out, pix_color_out, pix_sw_out
    );
endinterface

// File: rtl/remote_stroke_interp.sv
// Queues received remote cursor codes and redraws the path between consecutive
// points as a gap-free Bresenham pixel stream, one pixel per cycle.
module remote_stroke_interp #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned X_MAX      = 319,
    parameter int unsigned Y_MAX      = 179,
    parameter int unsigned JUMP_LIMIT = 64
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    remote_stroke_interp_if.slave  link,
    output logic                   busy_out,
    output logic [7:0]             drop_count_out,
    output logic [7:0]             reject_count_out
);
    localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);
    localparam logic [9:0]      XMaxC     = 10'(X_MAX);
    localparam logic [8:0]      YMaxC     = 9'(Y_MAX);
    localparam logic [9:0]      JumpC     = 10'(JUMP_LIMIT);

    typedef enum logic [1:0] {StIdle, StLoad, StSetup, StStep} state_e;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    // ---------------- input filter and FIFO ----------------
    logic [25:0]     fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic [25:0]     last_code_q;
    logic            last_valid_q;
    logic [7:0]      drop_q, reject_q;
    logic            in_range, is_dup, want_push, fifo_full, pop, push, drop, reject;
    logic [25:0]     head_code;
    state_e          state_q, state_d;

    assign in_range  = (link.code_in[25:16] <= XMaxC) && (link.code_in[15:7] <= YMaxC);
    assign is_dup    = last_valid_q && (link.code_in == last_code_q);
    assign want_push = link.new_code_in && in_range && !is_dup;
    assign fifo_full = (count_q == FullCount);
    assign pop       = (state_q == StIdle) && (count_q != '0);
    // A full FIFO still accepts when the engine pops in the same cycle.
    assign push      = want_push && (!fifo_full || pop);
    assign drop      = want_push && fifo_full && !pop;
    assign reject    = link.new_code_in && !in_range;
    assign head_code = fifo_mem[rd_ptr_q];

    // FIFO storage; contents need no reset because count_q qualifies them.
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr_q] <= link.code_in;
    end

    // FIFO pointers, duplicate tracker and saturating error counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_code_q  <= '0;
            last_valid_q <= 1'b0;
            drop_q       <= '0;
            reject_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr_q     <= wr_ptr_q + PtrOne;
                last_code_q  <= link.code_in;
                last_valid_q <= 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
            if (push && !pop) count_q <= count_q + CountOne;
            else if (pop && !push) count_q <= count_q - CountOne;
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            if (reject && reject_q != 8'hFF) reject_q <= reject_q + 8'd1;
        end
    end

    // ---------------- line engine ----------------
    logic [9:0]         tgt_x_q, tgt_x_d, prev_x_q, prev_x_d, cur_x_q, cur_x_d;
    logic [8:0]         tgt_y_q, tgt_y_d, prev_y_q, prev_y_d, cur_y_q, cur_y_d;
    logic [3:0]         tgt_color_q, tgt_color_d, prev_color_q, prev_color_d;
    logic [2:0]         tgt_sw_q, tgt_sw_d;
    logic               have_prev_q, have_prev_d, cont_q, cont_d;
    logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [11:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;

    logic [9:0]         diff_x, diff_y, jump_x, jump_y;
    logic               new_stroke, at_target;
    logic signed [11:0] setup_dx, setup_dy, setup_err;
    logic signed [11:0] a_dx, a_dy, a_err, e2, adv_err;
    logic               a_sx_neg, a_sy_neg;
    logic [9:0]         adv_x;
    logic [8:0]         adv_y;

    assign jump_x     = abs_diff(tgt_x_q, prev_x_q);
    assign jump_y     = abs_diff({1'b0, tgt_y_q}, {1'b0, prev_y_q});
    assign new_stroke = !have_prev_q || (jump_x > JumpC) || (jump_y > JumpC)
                        || (tgt_color_q != prev_color_q);
    assign diff_x     = abs_diff(tgt_x_q, cur_x_q);
    assign diff_y     = abs_diff({1'b0, tgt_y_q}, {1'b0, cur_y_q});
    assign setup_dx   = $signed({2'b00, diff_x});
    assign setup_dy   = -$signed({2'b00, diff_y});
    assign setup_err  = setup_dx + setup_dy;
    assign at_target  = (cur_x_q == tgt_x_q) && (cur_y_q == tgt_y_q);

    // One Bresenham advance; SETUP feeds it the freshly computed deltas.
    always_comb begin
        if (state_q == StSetup) begin
            a_dx     = setup_dx;
            a_dy     = setup_dy;
            a_err    = setup_err;
            a_sx_neg = tgt_x_q < cur_x_q;
            a_sy_neg = tgt_y_q < cur_y_q;
        end else begin
            a_dx     = dx_q;
            a_dy     = dy_q;
            a_err    = err_q;
            a_sx_neg = sx_neg_q;
            a_sy_neg = sy_neg_q;
        end
        e2      = a_err <<< 1;
        adv_err = a_err;
        adv_x   = cur_x_q;
        adv_y   = cur_y_q;
        if (e2 >= a_dy) begin
            adv_err = adv_err + a_dy;
            adv_x   = a_sx_neg ? cur_x_q - 10'd1 : cur_x_q + 10'd1;
        end
        if (e2 <= a_dx) begin
            adv_err = adv_err + a_dx;
            adv_y   = a_sy_neg ? cur_y_q - 9'd1 : cur_y_q + 9'd1;
        end
    end

    // Next-state and datapath update for the line engine.
    always_comb begin
        state_d      = state_q;
        tgt_x_d      = tgt_x_q;
        tgt_y_d      = tgt_y_q;
        tgt_color_d  = tgt_color_q;
        tgt_sw_d     = tgt_sw_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_color_d = prev_color_q;
        have_prev_d  = have_prev_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        cont_d       = cont_q;
        sx_neg_d     = sx_neg_q;
        sy_neg_d     = sy_neg_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    tgt_x_d     = head_code[25:16];
                    tgt_y_d     = head_code[15:7];
                    tgt_color_d = head_code[6:3];
                    tgt_sw_d    = head_code[2:0];
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                cont_d  = !new_stroke;
                cur_x_d = new_stroke ? tgt_x_q : prev_x_q;
                cur_y_d = new_stroke ? tgt_y_q : prev_y_q;
                state_d = StSetup;
            end
            StSetup: begin
                dx_d     = setup_dx;
                dy_d     = setup_dy;
                err_d    = setup_err;
                sx_neg_d = a_sx_neg;
                sy_neg_d = a_sy_neg;
                state_d  = StStep;
                if (cont_q) begin
                    // Continuation start pixel was already drawn by the last segment.
                    if (at_target) begin
                        prev_x_d     = tgt_x_q;
                        prev_y_d     = tgt_y_q;
                        prev_color_d = tgt_color_q;
                        have_prev_d  = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        cur_x_d = adv_x;
                        cur_y_d = adv_y;
                        err_d   = adv_err;
                    end
                end
            end
            StStep: begin
                if (link.pix_ready_in) begin
                    if (at_target) begin
                        prev_x_d     = tgt_x_q;
                        prev_y_d     = tgt_y_q;
                        prev_color_d = tgt_color_q;
                        have_prev_d  = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        cur_x_d = adv_x;
                        cur_y_d = adv_y;
                        err_d   = adv_err;
                    end
                end
            end
        endcase
    end

    // Line engine state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            tgt_x_q      <= '0;
            tgt_y_q      <= '0;
            tgt_color_q  <= '0;
            tgt_sw_q     <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_color_q <= '0;
            have_prev_q  <= 1'b0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            cont_q       <= 1'b0;
            sx_neg_q     <= 1'b0;
            sy_neg_q     <= 1'b0;
            dx_q         <= '0;
            dy_q         <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            tgt_x_q      <= tgt_x_d;
            tgt_y_q      <= tgt_y_d;
            tgt_color_q  <= tgt_color_d;
            tgt_sw_q     <= tgt_sw_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_color_q <= prev_color_d;
            have_prev_q  <= have_prev_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            cont_q       <= cont_d;
            sx_neg_q     <= sx_neg_d;
            sy_neg_q     <= sy_neg_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            err_q        <= err_d;
        end
    end

    assign link.pix_valid_out = (state_q == StStep);
    assign link.pix_x_out     = cur_x_q;
    assign link.pix_y_out     = cur_y_q;
    assign link.pix_color_out = tgt_color_q;
    assign link.pix_sw_out    = tgt_sw_q;
    assign busy_out           = (count_q != '0) || (state_q != StIdle);
    assign drop_count_out     = drop_q;
    assign reject_count_out   = reject_q;
endmodule
